// File: rtl/uart_rx_frame_if.sv
// Receive-side word handshake for uart_rx_frame.
// master = deserialiser, slave = consumer.
interface uart_rx_frame_if #(
   parameter int DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   modport master (
      output rx_data, rx_valid,
      output frame_err, parity_err, overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid,
      input  frame_err, parity_err, overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampled UART receive deserialiser with valid/ready output.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic baud_tick,
   input  logic rxd,
   uart_rx_frame_if.master rx
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] TOP  = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;

   state_t               state, state_n;
   logic                 meta, sync;
   logic [TW-1:0]        tick_cnt, tick_n;
   logic [IW-1:0]        bit_idx, idx_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic                 done;
   logic                 accept;
   logic [DATA_BITS-1:0] data_n;
   logic                 valid_n, ferr_n, perr_o_n, ovr_n;
`ifdef UART_RX_PARITY_EN
   logic                 perr, perr_n;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         sync <= 1'b1;
      end else begin
         meta <= rxd;
         sync <= meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         tick_cnt      <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         rx.rx_data    <= '0;
         rx.rx_valid   <= 1'b0;
         rx.frame_err  <= 1'b0;
         rx.parity_err <= 1'b0;
         rx.overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr          <= 1'b0;
`endif
      end else begin
         state         <= state_n;
         tick_cnt      <= tick_n;
         bit_idx       <= idx_n;
         shift         <= shift_n;
         rx.rx_data    <= data_n;
         rx.rx_valid   <= valid_n;
         rx.frame_err  <= ferr_n;
         rx.parity_err <= perr_o_n;
         rx.overrun    <= ovr_n;
`ifdef UART_RX_PARITY_EN
         perr          <= perr_n;
`endif
      end
   end

   // Bits arrive LSB first, so shifting in at the top leaves bit 0 in the LSB.
   always_comb begin
      state_n = state;
      tick_n  = tick_cnt;
      idx_n   = bit_idx;
      shift_n = shift;
      done    = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_n  = perr;
`endif
      if (baud_tick) begin
         unique case (state)
            IDLE: begin
               if (!sync) begin
                  state_n = START;
                  tick_n  = '0;
               end
            end
            START: begin
               if (tick_cnt == HALF) begin
                  tick_n = '0;
                  idx_n  = '0;
                  state_n = sync ? IDLE : DATA;
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
            DATA: begin
               if (tick_cnt == LAST) begin
                  tick_n  = '0;
                  shift_n = {sync, shift[DATA_BITS-1:1]};
                  idx_n   = bit_idx + 1'b1;
                  if (bit_idx == TOP) begin
`ifdef UART_RX_PARITY_EN
                     state_n = PARITY;
`else
                     state_n = STOP;
`endif
                  end
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick_cnt == LAST) begin
                  tick_n  = '0;
                  perr_n  = (^shift) ^ sync ^ PARITY_ODD[0];
                  state_n = STOP;
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (tick_cnt == LAST) begin
                  tick_n  = '0;
                  done    = 1'b1;
                  state_n = IDLE;
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // A completing frame may replace the held word only if it leaves now.
   always_comb begin
      accept   = rx.rx_valid && rx.rx_ready;
      data_n   = rx.rx_data;
      valid_n  = rx.rx_valid;
      ferr_n   = rx.frame_err;
      perr_o_n = rx.parity_err;
      ovr_n    = rx.overrun;
      if (accept) begin
         valid_n = 1'b0;
         ovr_n   = 1'b0;
      end
      if (done) begin
         if (!rx.rx_valid || accept) begin
            data_n  = shift;
            valid_n = 1'b1;
            ferr_n  = ~sync;
`ifdef UART_RX_PARITY_EN
            perr_o_n = perr;
`else
            perr_o_n = 1'b0;
`endif
         end else begin
            ovr_n = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: stimulus pushes expected words,
// a monitor pops and compares on each handshake.
module tb_uart_rx_frame;
   localparam int DB  = 8;
   localparam int OS  = 16;
   localparam int ODD = 0;
   localparam int BIT_CLK = OS * 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic baud_tick = 1'b0;
   logic rxd = 1'b1;

   uart_rx_frame_if #(.DATA_BITS(DB)) rx ();

   uart_rx_frame #(
      .DATA_BITS (DB),
      .OVERSAMPLE(OS),
      .PARITY_ODD(ODD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .baud_tick(baud_tick),
      .rxd      (rxd),
      .rx       (rx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       fe;
      logic       pe;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   auto_ready = 1'b1;
   bit   pulse_req = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, want,
                  $time);
      end
   endtask

   // Reference: word is the bits as sent; parity error when the total
   // count of ones (data + parity bit + odd select) is odd.
   function automatic exp_t model(input logic [7:0] d, input bit pbit,
                                  input bit stop);
      exp_t m;
      m.data = d;
      m.fe   = !stop;
`ifdef UART_RX_PARITY_EN
      m.pe   = (($countones(d) + int'(pbit) + ODD) % 2) == 1;
`else
      m.pe   = 1'b0;
`endif
      return m;
   endfunction

   function automatic bit good_par(input logic [7:0] d);
      return bit'(($countones(d) + ODD) % 2);
   endfunction

   initial begin : tickgen
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         baud_tick = (c == 3);
         c = (c + 1) % 4;
      end
   end

   initial begin : monitor
      exp_t e;
      rx.rx_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (auto_ready)
            rx.rx_ready = ($urandom_range(0, 3) != 0);
         else if (pulse_req) begin
            rx.rx_ready = 1'b1;
            pulse_req = 1'b0;
         end else
            rx.rx_ready = 1'b0;
         if (rx.rx_valid && rx.rx_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_word got %0h want none",
                        rx.rx_data);
            end else begin
               e = exp_q.pop_front();
               chk("rx_data", 32'(rx.rx_data), 32'(e.data));
               chk("frame_err", 32'(rx.frame_err), 32'(e.fe));
               chk("parity_err", 32'(rx.parity_err), 32'(e.pe));
            end
         end
      end
   end

   task automatic bit_time(input bit b);
      rxd = b;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit pbit,
                             input bit stop, input bit deliver);
      if (deliver) exp_q.push_back(model(d, pbit, stop));
      bit_time(1'b0);
      for (int i = 0; i < DB; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
      bit_time(pbit);
`endif
      bit_time(stop);
      bit_time(1'b1);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk(name, 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_valid"}, 32'(rx.rx_valid), 32'd0);
      chk({tag, "_data"}, 32'(rx.rx_data), 32'd0);
      chk({tag, "_ferr"}, 32'(rx.frame_err), 32'd0);
      chk({tag, "_perr"}, 32'(rx.parity_err), 32'd0);
      chk({tag, "_ovr"}, 32'(rx.overrun), 32'd0);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog got timeout want finish");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] d;
      bit         stop;
      bit         pbit;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk_outputs_zero("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      send_frame(8'hA5, good_par(8'hA5), 1'b1, 1'b1);
      wait_drain("drain_a5");
      chk("a5_valid_cleared", 32'(rx.rx_valid), 32'd0);

      rxd = 1'b0;
      repeat (3 * 4) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * BIT_CLK) @(negedge clk);
      chk("glitch_no_valid", 32'(rx.rx_valid), 32'd0);
      send_frame(8'h3C, good_par(8'h3C), 1'b1, 1'b1);
      wait_drain("drain_3c");

      send_frame(8'h3C, good_par(8'h3C), 1'b0, 1'b1);
      wait_drain("drain_3c_ferr");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h01, 1'b0, 1'b1, 1'b1);
      wait_drain("drain_par_bad");
      send_frame(8'h01, 1'b1, 1'b1, 1'b1);
      wait_drain("drain_par_ok");
`endif

      auto_ready = 1'b0;
      repeat (2) @(negedge clk);
      send_frame(8'h11, good_par(8'h11), 1'b1, 1'b1);
      send_frame(8'h22, good_par(8'h22), 1'b1, 1'b0);
      chk("ovr_valid", 32'(rx.rx_valid), 32'd1);
      chk("ovr_data_held", 32'(rx.rx_data), 32'h11);
      chk("ovr_flag", 32'(rx.overrun), 32'd1);
      pulse_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (!pulse_req) break;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      chk("ovr_valid_cleared", 32'(rx.rx_valid), 32'd0);
      chk("ovr_flag_cleared", 32'(rx.overrun), 32'd0);
      chk("ovr_queue", 32'(exp_q.size()), 32'd0);
      auto_ready = 1'b1;

      d = 8'h96;
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(d[i]);
      rxd = d[4];
      repeat (20) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_outputs_zero("midrst");
      rst = 1'b0;
      rxd = 1'b1;
      repeat (2 * BIT_CLK) @(negedge clk);
      chk("midrst_no_valid", 32'(rx.rx_valid), 32'd0);
      send_frame(8'h5A, good_par(8'h5A), 1'b1, 1'b1);
      wait_drain("drain_5a");

      for (int n = 0; n < 8; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         pbit = 1'($urandom);
         send_frame(d, pbit, stop, 1'b1);
         wait_drain("drain_rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
